// File: rtl/priority_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8to3
// Description : Registered MSB-first priority encoder with valid flag and
//               capture enable.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_8to3 #(
    parameter int WIDTH = 8,
    // Derived from WIDTH; leave at its default.
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [IDX_W-1:0] out,
    output logic             valid
);

    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_hit;
    logic [IDX_W-1:0] w_out_d;
    logic             w_valid_d;
    logic [IDX_W-1:0] r_out_q;
    logic             r_valid_q;

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        w_enc_idx = '0;
        w_enc_hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                w_enc_idx = IDX_W'(i);
                w_enc_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_out_d   = r_out_q;
        w_valid_d = r_valid_q;
        if (en) begin
            w_out_d   = w_enc_idx;
            w_valid_d = w_enc_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_out_q   <= w_out_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign out   = r_out_q;
    assign valid = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_8to3
// Description : Directed and random checks of the priority encoder against a
//               log2-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_8to3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [7:0]  in8 = 8'hFF;
    logic [2:0]  out8;
    logic        valid8;
    logic [15:0] in16 = 16'h0000;
    logic [3:0]  out16;
    logic        valid16;

    int n_checks = 0;
    int n_err    = 0;
    int exp_out  = 0;
    int exp_val  = 0;

    always #5 clk = ~clk;

    priority_encoder_8to3 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in(in8), .en(en), .out(out8), .valid(valid8)
    );

    priority_encoder_8to3 #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in(in16), .en(en), .out(out16), .valid(valid16)
    );

    // Highest set bit index = floor(log2(v)); zero vector maps to 0.
    function automatic int ref_idx(int v);
        return (v == 0) ? 0 : $clog2(v + 1) - 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply8(input string tag, input logic [7:0] v);
        in8 = v;
        tick();
        check({tag, ".out"}, int'(out8), ref_idx(int'(v)));
        check({tag, ".valid"}, int'(valid8), (v != 0) ? 1 : 0);
    endtask

    initial begin
        // Reset state
        tick();
        check("reset.out", int'(out8), 0);
        check("reset.valid", int'(valid8), 0);
        @(negedge clk);
        rst = 1'b0;

        // Capture 0xFF, then assert reset asynchronously mid-cycle
        apply8("pre_rst", 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.out", int'(out8), 0);
        check("async_rst.valid", int'(valid8), 0);
        tick();
        check("rst_held.out", int'(out8), 0);
        check("rst_held.valid", int'(valid8), 0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive sweep, one value per cycle
        for (int v = 0; v < 256; v++) apply8("sweep", 8'(v));

        // Zero vector then bit 0 only
        apply8("zero", 8'h00);
        apply8("bit0", 8'h01);

        // One-hot walk
        for (int k = 0; k < 8; k++) apply8("onehot", 8'(1 << k));

        // Enable hold
        apply8("hold_cap", 8'h24);
        en  = 1'b0;
        in8 = 8'h01;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hold.out", int'(out8), 5);
            check("hold.valid", int'(valid8), 1);
        end
        en = 1'b1;
        tick();
        check("release.out", int'(out8), 0);
        check("release.valid", int'(valid8), 1);

        // Random in/en with model tracking held values
        exp_out = 0;
        exp_val = 1;
        for (int r = 0; r < 300; r++) begin
            in8 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) in8 = 8'h00;
            en  = ($urandom_range(0, 3) != 0);
            if (en) begin
                exp_out = ref_idx(int'(in8));
                exp_val = (in8 != 0) ? 1 : 0;
            end
            tick();
            check("rand.out", int'(out8), exp_out);
            check("rand.valid", int'(valid8), exp_val);
        end
        en = 1'b1;

        // Wide instance
        in16 = 16'h8001;
        tick();
        check("w16_8001.out", int'(out16), 15);
        check("w16_8001.valid", int'(valid16), 1);
        in16 = 16'h0100;
        tick();
        check("w16_0100.out", int'(out16), 8);
        in16 = 16'h0000;
        tick();
        check("w16_zero.valid", int'(valid16), 0);
        for (int r = 0; r < 50; r++) begin
            in16 = 16'($urandom);
            tick();
            check("w16_rand.out", int'(out16), ref_idx(int'(in16)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
